// File: rtl/encode.sv
// ----------------------------------------------------------------------------
// encode: GF(2) vector-matrix encoder, codeword = info_bits x generator.
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      asynchronous, active-low reset
//   i_en       encode enable; samples info_bits/generator on the clk edge
//   info_bits  [K-1:0]   information word, bit K-1 is message bit 0
//   generator  [K*N-1:0] K x N matrix, row-major, MSB-first
//   codeword   [N-1:0]   registered product, bit N-1 is column 0
//   o_valid    high for the cycle after each enabled encode
// ----------------------------------------------------------------------------
module encode #(
    parameter int unsigned N = 11,
    parameter int unsigned K = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [K-1:0]     info_bits,
    input  logic [K*N-1:0]   generator,
    output logic [N-1:0]     codeword,
    output logic             o_valid
);

    localparam int unsigned GW = K * N;

    // Reject illegal code dimensions at elaboration.
    if (N < 2 || K < 1 || K >= N) begin : g_param_check
        $error("encode: illegal parameters N=%0d K=%0d", N, K);
    end

    // Running XOR of the generator rows selected by the message bits.
    logic [N-1:0] partial_c [K+1];

    assign partial_c[0] = '0;

    for (genvar r = 0; r < K; r++) begin : g_row
        logic [N-1:0] row_c;
        assign row_c          = generator[GW-1-r*N -: N];
        assign partial_c[r+1] = partial_c[r] ^ (row_c & {N{info_bits[K-1-r]}});
    end

    // Output register: load on enable, hold codeword otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            codeword <= '0;
            o_valid  <= 1'b0;
        end else begin
            o_valid <= i_en;
            if (i_en) begin
                codeword <= partial_c[K];
            end
        end
    end

endmodule

// File: tb/tb_encode.sv
// ----------------------------------------------------------------------------
// tb_encode: directed bench for encode (N=11, K=6) with an expected-value
// queue filled at drive time and drained when the result is sampled.
// ----------------------------------------------------------------------------
module tb_encode;

    localparam int unsigned N  = 11;
    localparam int unsigned K  = 6;
    localparam int unsigned GW = K * N;

    logic            clk;
    logic            rst_n;
    logic            i_en;
    logic [K-1:0]    info_bits;
    logic [GW-1:0]   generator;
    logic [N-1:0]    codeword;
    logic            o_valid;

    logic [GW-1:0]   g_ref;
    logic [N-1:0]    exp_q [$];

    int compared;
    int mismatched;

    encode #(.N(N), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (i_en),
        .info_bits (info_bits),
        .generator (generator),
        .codeword  (codeword),
        .o_valid   (o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Column-by-column reference product.
    function automatic logic [N-1:0] model(input logic [K-1:0] info, input logic [GW-1:0] g);
        logic [N-1:0] cw;
        cw = '0;
        for (int c = 0; c < N; c++) begin
            for (int r = 0; r < K; r++) begin
                cw[N-1-c] = cw[N-1-c] ^ (info[K-1-r] & g[GW-1-r*N-c]);
            end
        end
        return cw;
    endfunction

    task automatic check_word(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: codeword observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: o_valid observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare against the registered output.
    task automatic check_result(input string tag);
        logic [N-1:0] exp;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s: scoreboard empty, observed %b", tag, codeword);
        end else begin
            exp = exp_q.pop_front();
            check_word(tag, codeword, exp);
        end
        check_bit({tag, "_valid"}, o_valid, 1'b1);
    endtask

    // Drive one enabled encode with an explicit expected codeword.
    task automatic enc_exp(input string tag, input logic [K-1:0] info, input logic [N-1:0] exp);
        @(negedge clk);
        info_bits = info;
        i_en      = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check_result(tag);
    endtask

    // Drive one enabled encode checked against the reference model.
    task automatic enc_model(input string tag, input logic [K-1:0] info);
        enc_exp(tag, info, model(info, generator));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        g_ref = {11'b10000010100, 11'b01000010010, 11'b00100010001,
                 11'b00010001100, 11'b00001001010, 11'b00000101001};

        rst_n     = 1'b0;
        i_en      = 1'b0;
        info_bits = '0;
        generator = g_ref;
        #12;
        check_word("reset_cw", codeword, 11'b0);
        check_bit("reset_valid", o_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Spec vectors, first enabled edge after reset included.
        enc_exp("all_ones", 6'b111111, 11'b11111111000);

        // Hold: disabled edge keeps codeword and clears o_valid.
        @(negedge clk);
        i_en      = 1'b0;
        info_bits = 6'b000001;
        @(posedge clk);
        #1;
        check_word("hold_cw", codeword, 11'b11111111000);
        check_bit("hold_valid", o_valid, 1'b0);
        @(posedge clk);
        #1;
        check_word("hold2_cw", codeword, 11'b11111111000);

        enc_exp("row0", 6'b100000, 11'b10000010100);
        enc_exp("row5", 6'b000001, 11'b00000101001);
        enc_exp("rows01", 6'b110000, 11'b11000000110);
        enc_exp("zero", 6'b000000, 11'b00000000000);

        // Back-to-back with i_en held high across edges.
        enc_exp("b2b_0", 6'b100000, 11'b10000010100);
        enc_exp("b2b_1", 6'b000001, 11'b00000101001);
        enc_exp("b2b_2", 6'b111111, 11'b11111111000);

        // Inputs changing between edges must not leak to the outputs.
        @(negedge clk);
        i_en      = 1'b0;
        @(posedge clk);
        #1;
        info_bits = 6'b010101;
        generator = ~g_ref;
        #2;
        check_word("no_leak_cw", codeword, 11'b11111111000);
        check_bit("no_leak_valid", o_valid, 1'b0);
        generator = g_ref;

        // Model-checked sweep of the spec generator.
        for (int i = 0; i < 8; i++) begin
            enc_model("sweep", 6'($urandom_range(0, 63)));
        end

        // Non-systematic random generators, including the all-zero word.
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            generator = {$urandom, $urandom, $urandom};
            enc_model("randg", 6'($urandom_range(1, 63)));
            enc_model("randg_zero", 6'b000000);
        end
        generator = g_ref;

        // Async reset between edges, with an encode pending.
        @(negedge clk);
        info_bits = 6'b110000;
        i_en      = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_word("async_rst_cw", codeword, 11'b0);
        check_bit("async_rst_valid", o_valid, 1'b0);
        @(posedge clk);
        #1;
        check_word("rst_held_cw", codeword, 11'b0);
        check_bit("rst_held_valid", o_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        i_en  = 1'b0;
        enc_exp("post_rst", 6'b110000, 11'b11000000110);

        @(negedge clk);
        i_en = 1'b0;
        @(posedge clk);
        #1;
        check_bit("final_idle_valid", o_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
